// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: loads a word and length, then shifts
// it out MSB-first with hold, repeat, done and illegal-length error.
module seq_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Load_Valid,
    input  logic [WIDTH-1:0] Load_Data,
    input  logic [LEN_W-1:0] Load_Len,
    input  logic             Repeat,
    input  logic             Hold,
    output logic             Load_Ready,
    output logic             Out1,
    output logic             Out_Valid,
    output logic             Done,
    output logic             Err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             len_ok;

    assign len_ok = (Load_Len != '0) && (Load_Len <= MAX_LEN);

    // State and datapath registers; reset abandons any pattern in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            word_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            word_q  <= word_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: load, shift with hold, and done/repeat decision
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        word_d  = word_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Load_Valid) begin
                    if (len_ok) begin
                        sr_d    = Load_Data;
                        word_d  = Load_Data;
                        len_d   = Load_Len;
                        cnt_d   = Load_Len;
                        state_d = S_SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (!Hold) begin
                    sr_d = {sr_q[WIDTH-2:0], 1'b0};
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - ONE;
                    end
                    // A zero count cannot occur here, but must not stall
                    if (cnt_q <= ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (Repeat) begin
                    sr_d    = word_q;
                    cnt_d   = len_q;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Load_Ready = (state_q == S_IDLE);
    assign Out_Valid  = (state_q == S_SHIFT);
    assign Out1       = (state_q == S_SHIFT) & sr_q[WIDTH-1];
    assign Done       = (state_q == S_DONE);
    assign Err        = err_q;

endmodule
